// File: rtl/vdp_pkg.sv
// Shared VDP CPU-port definitions: control command codes, phase and bus-state
// encodings, and the tick-priority helper.
package vdp_pkg;

   localparam logic [1:0] CMD_REG   = 2'b10;
   localparam logic [1:0] CMD_WADDR = 2'b01;
   localparam logic [1:0] CMD_RADDR = 2'b00;

   typedef enum logic {FIRST, SECOND} phase_t;

   typedef enum logic [1:0] {IDLE, WR_PEND, RD_PEND} bus_state_t;

   typedef struct packed {
      logic wr1;
      logic rd1;
      logic wr0;
      logic rd0;
   } tick_t;

   // Keep only the highest-priority strobe: wr1 > rd1 > wr0 > rd0.
   function automatic tick_t tick_prio(input tick_t t);
      tick_t r;
      r.wr1 = t.wr1;
      r.rd1 = t.rd1 & ~t.wr1;
      r.wr0 = t.wr0 & ~(t.wr1 | t.rd1);
      r.rd0 = t.rd0 & ~(t.wr1 | t.rd1 | t.wr0);
      return r;
   endfunction

endpackage

// File: rtl/vdp_cpu_ifce_if.sv
// VRAM arbiter handshake between the VDP CPU port (master) and the arbiter (slave).
interface vdp_cpu_ifce_if #(
   parameter int REG_W  = 8,
   parameter int ADDR_W = 14
) ();
   logic [ADDR_W-1:0] vram_addr;
   logic              vram_req;
   logic              vram_we;
   logic [REG_W-1:0]  vram_wdata;
   logic              vram_ack;
   logic [REG_W-1:0]  vram_rdata;

   modport master (
      output vram_addr, vram_req, vram_we, vram_wdata,
      input  vram_ack, vram_rdata
   );

   modport slave (
      input  vram_addr, vram_req, vram_we, vram_wdata,
      output vram_ack, vram_rdata
   );
endinterface

// File: rtl/vdp_vram_port.sv
// VRAM side of the CPU port: bus FSM, auto-increment address, read-ahead buffer
// and sticky overrun flag.
module vdp_vram_port
   import vdp_pkg::*;
#(
   parameter int REG_W  = 8,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr0_go,
   input  logic              rd0_go,
   input  logic              rd1_go,
   input  logic              addr_load,
   input  logic              addr_prefetch,
   input  logic [ADDR_W-1:0] addr_val,
   input  logic [REG_W-1:0]  din,
   output logic [REG_W-1:0]  dout,
   output logic              overrun,
   vdp_cpu_ifce_if.master    vram
);

   bus_state_t        state;
   logic [ADDR_W-1:0] addr;
   logic              req;
   logic              we;
   logic [REG_W-1:0]  wdata;

   assign vram.vram_addr  = addr;
   assign vram.vram_req   = req;
   assign vram.vram_we    = we;
   assign vram.vram_wdata = wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         addr    <= '0;
         req     <= 1'b0;
         we      <= 1'b0;
         wdata   <= '0;
         dout    <= '0;
         overrun <= 1'b0;
      end else begin
         if (rd1_go)
            overrun <= 1'b0;
         case (state)
            IDLE: begin
               if (wr0_go) begin
                  wdata <= din;
                  we    <= 1'b1;
                  req   <= 1'b1;
                  state <= WR_PEND;
               end else if (rd0_go) begin
                  we    <= 1'b0;
                  req   <= 1'b1;
                  state <= RD_PEND;
               end else if (addr_load) begin
                  addr <= addr_val;
                  if (addr_prefetch) begin
                     we    <= 1'b0;
                     req   <= 1'b1;
                     state <= RD_PEND;
                  end
               end
            end
            default: begin
               // Anything touching the bus while a transfer is open is lost.
               if (wr0_go || rd0_go || addr_load)
                  overrun <= 1'b1;
               if (vram.vram_ack) begin
                  if (state == RD_PEND)
                     dout <= vram.vram_rdata;
                  addr  <= addr + ADDR_W'(1);
                  req   <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/vdp_cpu_ifce.sv
// VDP CPU port top: control-phase FSM and config register array; VRAM access in vdp_vram_port.
// Define VDP_CPU_IFCE_REG_RESET_EN to clear the config registers on reset.
module vdp_cpu_ifce
   import vdp_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int REG_W    = 8,
   parameter int ADDR_W   = 14
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr1_tick,
   input  logic                      rd1_tick,
   input  logic                      wr0_tick,
   input  logic                      rd0_tick,
   input  logic [REG_W-1:0]          din,
   output logic [NUM_REGS*REG_W-1:0] regs,
   output logic [REG_W-1:0]          dout,
   output logic                      overrun,
   vdp_cpu_ifce_if.master            vram
);

   tick_t  tk;
   phase_t phase;
   logic [REG_W-1:0] w0;

   assign tk = tick_prio('{wr1: wr1_tick, rd1: rd1_tick, wr0: wr0_tick, rd0: rd0_tick});

   logic       second;
   logic [1:0] cmd;
   logic [5:0] idx;
   logic       reg_we;
   logic       addr_load;
   logic [REG_W+5:0] addr_full;

   assign second    = tk.wr1 && (phase == SECOND);
   assign cmd       = din[7:6];
   assign idx       = din[5:0];
   assign reg_we    = second && (cmd == CMD_REG) && (32'(idx) < 32'(NUM_REGS));
   assign addr_load = second && ((cmd == CMD_WADDR) || (cmd == CMD_RADDR));
   assign addr_full = {idx, w0};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= FIRST;
         w0    <= '0;
      end else if (tk.wr1) begin
         if (phase == FIRST) begin
            w0    <= din;
            phase <= SECOND;
         end else begin
            phase <= FIRST;
         end
      end else if (tk.rd1 || tk.wr0 || tk.rd0) begin
         phase <= FIRST;
      end
   end

   logic [NUM_REGS-1:0][REG_W-1:0] reg_q;
   assign regs = reg_q;

`ifdef VDP_CPU_IFCE_REG_RESET_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         reg_q <= '0;
      else
         for (int i = 0; i < NUM_REGS; i++)
            if (reg_we && idx == 6'(i))
               reg_q[i] <= w0;
   end
`else
   // No reset so the array can map onto distributed RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++)
         if (reg_we && idx == 6'(i))
            reg_q[i] <= w0;
   end
`endif

   vdp_vram_port #(.REG_W(REG_W), .ADDR_W(ADDR_W)) u_vram_port (
      .clk           (clk),
      .reset         (reset),
      .wr0_go        (tk.wr0),
      .rd0_go        (tk.rd0),
      .rd1_go        (tk.rd1),
      .addr_load     (addr_load),
      .addr_prefetch (cmd == CMD_RADDR),
      .addr_val      (ADDR_W'(addr_full)),
      .din           (din),
      .dout          (dout),
      .overrun       (overrun),
      .vram          (vram)
   );

endmodule
